// File: rtl/alu_op_sequencer.sv
`default_nettype none
//============================================================================
// Module   : alu_op_sequencer
// Purpose  : Control sequencer for a single-bus register-file/ALU datapath.
//            Accepts one ALU command at a time and walks it through
//            Y-load, operate, Z-low write-back and optional Z-high
//            write-back. Every output is a Moore decode of the state and
//            the fields latched when the command was accepted.
// Ports    : Clock, clear (async, active-high)
//            start, op, unary, wide, ra, rb, rc, rhi  - command request
//            Rout, Rin                                - one-hot register enables
//            Yin, ZHighin, Zlowin, Zhighout, Zlowout  - datapath strobes
//            alu_op                                   - ALU operation code
//            busy, done, err                          - status
// Revision : 1.0 - initial release
//============================================================================
module alu_op_sequencer #(
   parameter int DATA_W = 32,
   parameter int NREG   = 16,
   parameter int OP_W   = 5,
   localparam int RIDX_W = $clog2(NREG)
) (
   input  logic              Clock,
   input  logic              clear,
   input  logic              start,
   input  logic [OP_W-1:0]   op,
   input  logic              unary,
   input  logic              wide,
   input  logic [RIDX_W-1:0] ra,
   input  logic [RIDX_W-1:0] rb,
   input  logic [RIDX_W-1:0] rc,
   input  logic [RIDX_W-1:0] rhi,
   output logic [NREG-1:0]   Rout,
   output logic [NREG-1:0]   Rin,
   output logic              Yin,
   output logic              ZHighin,
   output logic              Zlowin,
   output logic              Zhighout,
   output logic              Zlowout,
   output logic [OP_W-1:0]   alu_op,
   output logic              busy,
   output logic              done,
   output logic              err
);

   // DATA_W only sizes the datapath around this block; reject nonsense
   // parameter sets at elaboration time.
   generate
      if (DATA_W < 1 || NREG < 2 || OP_W < 1) begin : g_param_check
         $error("alu_op_sequencer: illegal parameter set");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LDY  = 3'd1,
      S_OPX  = 3'd2,
      S_ZLO  = 3'd3,
      S_ZHI  = 3'd4,
      S_DONE = 3'd5
   } state_t;

   // One extra bit so that NREG itself is representable for the range test.
   localparam logic [RIDX_W:0] c_nreg = (RIDX_W+1)'(NREG);
   localparam logic [NREG-1:0] c_one  = {{(NREG-1){1'b0}}, 1'b1};

   state_t            r_state;
   state_t            w_next_state;
   logic [OP_W-1:0]   r_op;
   logic              r_unary;
   logic              r_wide;
   logic [RIDX_W-1:0] r_ra;
   logic [RIDX_W-1:0] r_rb;
   logic [RIDX_W-1:0] r_rc;
   logic [RIDX_W-1:0] r_rhi;
   logic              r_err;

   logic w_bad;
   logic w_accept;
   logic w_reject;

   // Only the indices the command actually uses take part in the range check.
   assign w_bad = ({1'b0, ra} >= c_nreg) |
                  ({1'b0, rb} >= c_nreg) |
                  (~unary & ({1'b0, rc}  >= c_nreg)) |
                  (wide   & ({1'b0, rhi} >= c_nreg));

   assign w_accept = (r_state == S_IDLE) & start & ~w_bad;
   assign w_reject = (r_state == S_IDLE) & start &  w_bad;

   // State register, latched command fields and the registered error pulse.
   always_ff @(posedge Clock or posedge clear) begin
      if (clear) begin
         r_state <= S_IDLE;
         r_op    <= '0;
         r_unary <= 1'b0;
         r_wide  <= 1'b0;
         r_ra    <= '0;
         r_rb    <= '0;
         r_rc    <= '0;
         r_rhi   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_err   <= w_reject;
         if (w_accept) begin
            r_op    <= op;
            r_unary <= unary;
            r_wide  <= wide;
            r_ra    <= ra;
            r_rb    <= rb;
            r_rc    <= rc;
            r_rhi   <= rhi;
         end
      end
   end

   // Next-state and Moore output decode.
   always_comb begin
      w_next_state = r_state;
      Rout         = '0;
      Rin          = '0;
      Yin          = 1'b0;
      ZHighin      = 1'b0;
      Zlowin       = 1'b0;
      Zhighout     = 1'b0;
      Zlowout      = 1'b0;
      alu_op       = '0;
      done         = 1'b0;
      busy         = (r_state != S_IDLE);
      err          = r_err;

      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_next_state = unary ? S_OPX : S_LDY;
            end
         end
         S_LDY: begin
            Rout         = c_one << r_rb;
            Yin          = 1'b1;
            w_next_state = S_OPX;
         end
         S_OPX: begin
            // Unary ops take their only operand from rb straight off the bus.
            Rout         = c_one << (r_unary ? r_rb : r_rc);
            alu_op       = r_op;
            ZHighin      = 1'b1;
            Zlowin       = 1'b1;
            w_next_state = S_ZLO;
         end
         S_ZLO: begin
            Zlowout      = 1'b1;
            Rin          = c_one << r_ra;
            w_next_state = r_wide ? S_ZHI : S_DONE;
         end
         S_ZHI: begin
            Zhighout     = 1'b1;
            Rin          = c_one << r_rhi;
            w_next_state = S_DONE;
         end
         S_DONE: begin
            done         = 1'b1;
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire
